// File: rtl/need_monitor.sv
// Per-need debounced warning monitor with priority encode and latched DEAD state.
// Optional macro NEED_MONITOR_REVIVE_EN lets revive leave DEAD once all levels are calm.
module need_monitor #(
  parameter int NUM_NEEDS   = 6,
  parameter int LEVEL_W     = 4,
  parameter int WARN_LEVEL  = 12,
  parameter int DEAD_LEVEL  = 2**LEVEL_W-1,
  parameter int HOLD_CYCLES = 4,
  localparam int TW = (NUM_NEEDS > 1) ? $clog2(NUM_NEEDS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_NEEDS*LEVEL_W-1:0] levels,
  input  logic [NUM_NEEDS-1:0]         ack,
  input  logic                         revive,
  output logic [NUM_NEEDS-1:0]         warn,
  output logic                         dead,
  output logic [1:0]                   state,
  output logic [TW-1:0]                top_need,
  output logic                         top_valid,
  output logic                         alert
);

  typedef enum logic [1:0] {
    S_OK   = 2'b00,
    S_WARN = 2'b01,
    S_DEAD = 2'b10
  } state_t;

  localparam logic [7:0] HOLD = 8'(HOLD_CYCLES);

  state_t               st;
  logic [7:0]           cnt    [NUM_NEEDS];
  logic [7:0]           cnt_nx [NUM_NEEDS];
  logic [NUM_NEEDS-1:0] hi;
  logic [NUM_NEEDS-1:0] die;
  logic [NUM_NEEDS-1:0] set;
  logic [NUM_NEEDS-1:0] warn_nx;
  logic [TW-1:0]        enc;
  logic                 revive_ok;

  assign state = st;

  always_comb begin
    hi  = '0;
    die = '0;
    set = '0;
    for (int i = 0; i < NUM_NEEDS; i++) begin
      hi[i]  = levels[i*LEVEL_W +: LEVEL_W] >= LEVEL_W'(WARN_LEVEL);
      die[i] = levels[i*LEVEL_W +: LEVEL_W] >= LEVEL_W'(DEAD_LEVEL);
      if (!hi[i])
        cnt_nx[i] = 8'd0;
      else if (cnt[i] == HOLD)
        cnt_nx[i] = cnt[i];
      else
        cnt_nx[i] = cnt[i] + 8'd1;
      set[i] = hi[i] && (cnt_nx[i] == HOLD);
    end
    // set wins; a clear needs the level low, so it cannot coincide anyway
    warn_nx = set | (warn & ~(ack & ~hi));
  end

  always_comb begin
    enc = '0;
    for (int i = NUM_NEEDS-1; i >= 0; i--)
      if (warn_nx[i]) enc = TW'(i);
  end

`ifdef NEED_MONITOR_REVIVE_EN
  assign revive_ok = revive && !(|hi);
`else
  assign revive_ok = revive & 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_OK;
      warn      <= '0;
      dead      <= 1'b0;
      top_need  <= '0;
      top_valid <= 1'b0;
      alert     <= 1'b0;
      for (int i = 0; i < NUM_NEEDS; i++) cnt[i] <= 8'd0;
    end else begin
      case (st)
        S_DEAD: begin
          alert <= 1'b0;
          for (int i = 0; i < NUM_NEEDS; i++) cnt[i] <= 8'd0;
          if (revive_ok) begin
            st        <= S_OK;
            warn      <= '0;
            dead      <= 1'b0;
            top_need  <= '0;
            top_valid <= 1'b0;
          end
        end
        default: begin
          if (|die) begin
            st        <= S_DEAD;
            warn      <= '1;
            dead      <= 1'b1;
            top_need  <= '0;
            top_valid <= 1'b0;
            alert     <= 1'b0;
            for (int i = 0; i < NUM_NEEDS; i++) cnt[i] <= 8'd0;
          end else begin
            st        <= (|warn_nx) ? S_WARN : S_OK;
            warn      <= warn_nx;
            top_need  <= enc;
            top_valid <= |warn_nx;
            alert     <= |(warn_nx & ~warn);
            for (int i = 0; i < NUM_NEEDS; i++) cnt[i] <= cnt_nx[i];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_need_monitor.sv
// Directed bench for need_monitor at default parameters.
module tb_need_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] levels;
  logic [5:0]  ack;
  logic        revive;
  logic [5:0]  warn;
  logic        dead;
  logic [1:0]  state;
  logic [2:0]  top_need;
  logic        top_valid;
  logic        alert;

  int total = 0;
  int bad   = 0;

  need_monitor dut (
    .clk(clk), .rst(rst), .levels(levels), .ack(ack), .revive(revive),
    .warn(warn), .dead(dead), .state(state), .top_need(top_need),
    .top_valid(top_valid), .alert(alert)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lvl(input int i, input logic [3:0] v);
    levels[i*4 +: 4] = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [5:0] w,
                         input logic d, input logic [1:0] s,
                         input logic [2:0] tn, input logic tv,
                         input logic a);
    chk({tag, ".warn"}, 32'(warn), 32'(w));
    chk({tag, ".dead"}, 32'(dead), 32'(d));
    chk({tag, ".state"}, 32'(state), 32'(s));
    chk({tag, ".top_need"}, 32'(top_need), 32'(tn));
    chk({tag, ".top_valid"}, 32'(top_valid), 32'(tv));
    chk({tag, ".alert"}, 32'(alert), 32'(a));
  endtask

  initial begin
    rst = 1'b1; levels = '0; ack = '0; revive = 1'b0;
    step(2);
    rst = 1'b0;
    chk_all("reset", 6'b0, 0, 2'b00, 0, 0, 0);

    // three qualifying samples then a drop: no warning
    lvl(1, 12); step(3);
    chk("short_hold", 32'(warn), 0);
    lvl(1, 5); step();
    chk("drop_clears", 32'(warn), 0);
    lvl(1, 12); step(3);
    chk("hold3", 32'(warn), 0);
    step();
    chk_all("warn1", 6'b000010, 0, 2'b01, 1, 1, 1);
    step();
    chk_all("alert_once", 6'b000010, 0, 2'b01, 1, 1, 0);

    // second warning on need 3
    lvl(3, 12); step(4);
    chk_all("warn3", 6'b001010, 0, 2'b01, 1, 1, 1);
    lvl(1, 13); lvl(3, 2); ack = 6'b001010; step();
    chk_all("ack_high_ignored", 6'b000010, 0, 2'b01, 1, 1, 0);
    ack = '0; lvl(1, 0); step();
    chk("sticky_no_ack", 32'(warn), 32'(6'b000010));
    ack = 6'b000010; step();
    chk_all("ack_clear", 6'b0, 0, 2'b00, 0, 0, 0);
    ack = '0;

    // need 2 warning, then death on need 4
    lvl(2, 12); step(4);
    chk_all("warn2", 6'b000100, 0, 2'b01, 2, 1, 1);
    lvl(4, 15); step();
    chk_all("dead", 6'b111111, 1, 2'b10, 0, 0, 0);
    levels = '0; ack = '1; step(2);
    chk_all("dead_absorb", 6'b111111, 1, 2'b10, 0, 0, 0);
    ack = '0;

`ifdef NEED_MONITOR_REVIVE_EN
    lvl(0, 13); revive = 1'b1; step();
    chk_all("revive_blocked", 6'b111111, 1, 2'b10, 0, 0, 0);
    lvl(0, 0); step();
    chk_all("revive_ok", 6'b0, 0, 2'b00, 0, 0, 0);
    revive = 1'b0;
    lvl(4, 15); step();
    lvl(4, 0);
    chk("redie", 32'(dead), 1);
`else
    revive = 1'b1; step();
    chk_all("revive_ignored", 6'b111111, 1, 2'b10, 0, 0, 0);
    revive = 1'b0;
`endif

    // asynchronous reset in DEAD, away from any clock edge
    levels = '0;
    #2 rst = 1'b1;
    #1;
    chk_all("rst_dead", 6'b0, 0, 2'b00, 0, 0, 0);
    #1 rst = 1'b0;
    step();

    // reset mid-count must restart the hold counter
    lvl(0, 12); step(3);
    chk("midcount", 32'(warn), 0);
    #2 rst = 1'b1;
    #1;
    chk_all("rst_count", 6'b0, 0, 2'b00, 0, 0, 0);
    #1 rst = 1'b0;
    step();
    chk("count_restart", 32'(warn), 0);
    step(3);
    chk_all("warn0", 6'b000001, 0, 2'b01, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/need_monitor.md
# need_monitor

Parametrised per-need status monitor for the tamagotchi core. It replaces the fixed six-need, single-bit status logic with several features:
- a configurable number of needs, level width and thresholds;
- per-need debounced, sticky warning flags with acknowledge;
- a priority encoder that names the most urgent need;
- a latched DEAD state.

It sits between the need-level counters and the display/sound front end.

## Interface
Parameters:
- NUM_NEEDS, 6, number of monitored needs (1..16)
- LEVEL_W, 4, bit width of each need level
- WARN_LEVEL, 12, level at or above which a need qualifies for a warning
- DEAD_LEVEL, 2**LEVEL_W-1, level at or above which the pet dies
- HOLD_CYCLES, 4, consecutive qualifying samples required before a warning sets (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- levels  in  NUM_NEEDS*LEVEL_W  packed need levels; need i at bits [i*LEVEL_W +: LEVEL_W]
- ack  in  NUM_NEEDS  per-need warning acknowledge, sampled each edge
- revive  in  1  leave DEAD; used only with NEED_MONITOR_REVIVE_EN
- warn  out  NUM_NEEDS  sticky per-need warning flags
- dead  out  1  pet dead
- state  out  2  00 OK, 01 WARN, 10 DEAD
- top_need  out  $clog2(NUM_NEEDS) (min 1)  index of the lowest-numbered set warning
- top_valid  out  1  top_need is meaningful
- alert  out  1  one-cycle pulse when any warning bit rises

## Operation
- Reset: all outputs are zero, all hold counters are zero, and state is OK.
- Per-need hold counter:
  - Increments on each edge where level ≥ WARN_LEVEL, saturating at HOLD_CYCLES.
  - Clears to 0 on any edge where level < WARN_LEVEL.
- A warn[i] bit sets on the edge where need i's counter reaches HOLD_CYCLES.
- A warn[i] bit clears only when ack[i]=1 and level i < WARN_LEVEL at the same edge. An ack while the level is still high is ignored.
- If a set and a clear would happen on the same edge, the set takes priority. The clear needs the level low, so the two cannot actually collide.
- alert: asserted for one cycle after an edge where at least one warn bit went 0→1.
- State machine, evaluated each edge:
  - OK→WARN when any warn bit is set.
  - WARN→OK when all warn bits are clear.
  - OK/WARN→DEAD when any level ≥ DEAD_LEVEL. No debounce applies, and this transition takes priority over everything else.
  - DEAD is absorbing. Only rst exits it, or revive when the macro is enabled.
- In DEAD:
  - warn is all ones and dead=1.
  - top_valid=0, top_need=0, alert=0.
  - ack and hold counters are ignored; counters are held at 0.
- top_need/top_valid: registered priority encode of warn, lowest index wins. top_valid=1 whenever state is WARN.
- All levels are unsigned. Comparisons are ≥ at full LEVEL_W width.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Warning latency: with a level held at ≥ WARN_LEVEL from edge k, warn[i] is high after edge k+HOLD_CYCLES-1. alert is high during that same cycle. HOLD_CYCLES=1 gives a one-edge latency.
- top_need, top_valid and state update on the same edge as warn.
- Death latency: one edge after a level ≥ DEAD_LEVEL is sampled.
- Ack latency: warn[i] clears on the same edge that samples ack[i]=1 with the level low.
- rst asserted mid-operation forces reset values immediately, independent of clk.

## Configuration
- Macro: NEED_MONITOR_REVIVE_EN.
- Defined: revive=1 in DEAD moves the block to OK on the next edge, provided all levels are < WARN_LEVEL. It then clears warn and dead and zeroes the counters. If any level is still ≥ WARN_LEVEL, revive is ignored.
- Undefined: the revive port still exists but is ignored, and DEAD is left only through rst.

## Test plan
- Reset with levels all 0 → warn=0, dead=0, state=00, top_valid=0, alert=0.
- HOLD_CYCLES=4; levels[1]=12 for 3 edges, then 5 → warn stays 0. Then 12 for 4 edges → warn=6'b000010 after the 4th edge, alert pulses for one cycle, top_need=1, state=01.
- Warnings on needs 1 and 3; ack=6'b001010 while level 1 is still 13 and level 3 is 2 → warn=6'b000010, top_need=1. Lower level 1 and ack again → warn=0, state=00.
- Level 4 = 15 with warnings pending → after one edge dead=1, warn=6'b111111, state=10, top_valid=0. Subsequent ack and level drops leave it unchanged.
- With NEED_MONITOR_REVIVE_EN: in DEAD with level 0 = 13, revive=1 → still DEAD. After levels drop to 0, revive=1 → state=00, dead=0, warn=0. Without the macro, revive has no effect.
- rst pulse asserted mid-count and mid-DEAD → all outputs zero immediately, without waiting for a clk edge.
